// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loader_pkg
// Brief   : Shared state encoding and frame constants for the boot loader.
// Revision: 1.0 - initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;
  localparam int         C_MAX_WORDS = 1024;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : word_assembler
// Brief   : Packs data bytes big-endian into 32-bit words and XORs every byte.
// Revision: 1.0 - initial release
// ============================================================================
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [7:0]  xor_acc
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_acc      <= 8'd0;
    end else if (clr) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_acc      <= 8'd0;
    end else if (byte_en) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {r_shift[15:0], byte_in};
      r_acc      <= r_acc ^ byte_in;
    end
  end

  // The fourth byte completes the word combinationally; the top registers it.
  assign word_valid = byte_en && (r_byte_cnt == 2'd3);
  assign word_data  = {r_shift, byte_in};
  assign xor_acc    = r_acc;

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module  : im_loader
// Brief   : Framed byte-stream boot loader for im_4k; holds the CPU until the
//           image is written and its checksum matches.
// Revision: 1.0 - initial release
// ============================================================================
module im_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         MAX_WORDS = C_MAX_WORDS,
  parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int          c_cnt_w   = ADDR_W + 1;
  localparam logic [15:0] c_max_len = 16'(MAX_WORDS);

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_len;
  logic [15:0]         w_len_full;
  logic [ADDR_W:0]     r_word_cnt;
  logic [ADDR_W:0]     w_cnt_inc;
  logic                w_accept;
  logic                w_last_word;
  logic                w_word_valid;
  logic [31:0]         w_word_data;
  logic [7:0]          w_xor_acc;

  assign rx_ready = (r_state != RUN) && (r_state != ERR);
  assign w_accept = rx_valid && rx_ready;

  assign w_len_full  = {r_len[15:8], rx_data};
  assign w_cnt_inc   = r_word_cnt + c_cnt_w'(1);
  assign w_last_word = (16'(w_cnt_inc) == r_len);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_accept && (r_state == IDLE)),
    .byte_en    (w_accept && (r_state == DATA)),
    .byte_in    (rx_data),
    .word_valid (w_word_valid),
    .word_data  (w_word_data),
    .xor_acc    (w_xor_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      unique case (r_state)
        IDLE:    if (rx_data == SYNC_BYTE) w_state_next = LEN_HI;
        LEN_HI:  w_state_next = LEN_LO;
        LEN_LO: begin
          if (w_len_full > c_max_len)   w_state_next = ERR;
          else if (w_len_full == 16'd0) w_state_next = CHK;
          else                          w_state_next = DATA;
        end
        DATA:    if (w_word_valid && w_last_word) w_state_next = CHK;
        CHK:     w_state_next = (rx_data == w_xor_acc) ? RUN : ERR;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= 16'd0;
      r_word_cnt <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= 32'd0;
    end else begin
      im_we <= w_word_valid;
      if (w_accept && (r_state == LEN_HI)) r_len[15:8] <= rx_data;
      if (w_accept && (r_state == LEN_LO)) r_len[7:0]  <= rx_data;
      // Address uses the pre-increment count, so word N lands at address N.
      if (w_word_valid) begin
        im_addr    <= r_word_cnt[ADDR_W-1:0];
        im_wdata   <= w_word_data;
        r_word_cnt <= w_cnt_inc;
      end
    end
  end

  assign word_cnt = r_word_cnt;
  assign cpu_rst  = (r_state != RUN);
  assign done     = (r_state == RUN);
  assign error    = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_im_loader
// Brief   : Directed bench for im_loader with a write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [10:0] word_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [41:0] exp_q[$];

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && im_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(im_addr), 64'h3FF_DEAD);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_addr), 64'(e[41:32]));
        check("wr_data", 64'(im_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_we);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    check("we_after_byte", 64'(im_we), 64'(exp_we));
  endtask

  // Small frame model: predicts which bytes complete a word and what it is.
  task automatic run_frame(input logic [7:0] f[$], input int gap);
    int s = -1;
    int len = 0;
    int k;
    logic [31:0] w = 32'd0;
    for (int i = 0; i < f.size(); i++) begin
      logic we = 1'b0;
      if (s < 0) begin
        if (f[i] == 8'hA5) s = i;
      end else if (i == s + 2) begin
        len = {f[s+1], f[s+2]};
      end else if (i >= s + 3 && len <= 1024) begin
        k = i - s - 3;
        if (k < 4 * len) begin
          w = {w[23:0], f[i]};
          if (k % 4 == 3) begin
            we = 1'b1;
            exp_q.push_back({10'(k / 4), w});
          end
        end
      end
      send_byte(f[i], we);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1 check("we_in_gap", 64'(im_we), 64'd0);
      end
    end
  endtask

  task automatic check_outcome(input string tag, input logic exp_done, input logic exp_error,
                               input int exp_cnt);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done"},  64'(done),     64'(exp_done));
    check({tag, "_error"}, 64'(error),    64'(exp_error));
    check({tag, "_cpurst"}, 64'(cpu_rst), 64'(!exp_done));
    check({tag, "_ready"}, 64'(rx_ready), 64'(!(exp_done || exp_error)));
    check({tag, "_cnt"},   64'(word_cnt), 64'(exp_cnt));
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] part[$];
    logic [7:0] big[$];
    logic [7:0] chk;
    logic [31:0] w;

    good = '{8'h00, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
    bad  = good;
    bad[12] = 8'h26;

    // Reset state
    do_reset();
    #1;
    check("rst_cpurst", 64'(cpu_rst), 64'd1);
    check("rst_we",     64'(im_we),   64'd0);
    check("rst_done",   64'(done),    64'd0);
    check("rst_error",  64'(error),   64'd0);
    check("rst_cnt",    64'(word_cnt), 64'd0);
    check("rst_ready",  64'(rx_ready), 64'd1);
    check("rst_addr",   64'(im_addr),  64'd0);
    check("rst_wdata",  64'(im_wdata), 64'd0);

    // Valid image
    run_frame(good, 0);
    check_outcome("good", 1'b1, 1'b0, 2);

    // Bad checksum
    do_reset();
    run_frame(bad, 0);
    check_outcome("badchk", 1'b0, 1'b1, 2);

    // Oversize length
    do_reset();
    run_frame('{8'hA5, 8'h04, 8'h01}, 0);
    check_outcome("oversize", 1'b0, 1'b1, 0);

    // Empty image
    do_reset();
    run_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    check_outcome("empty", 1'b1, 1'b0, 0);

    // Gaps between every byte
    do_reset();
    run_frame(good, 3);
    check_outcome("gaps", 1'b1, 1'b0, 2);

    // Reset mid-load after six data bytes
    do_reset();
    part = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
    run_frame(part, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_cnt",    64'(word_cnt), 64'd0);
    check("midrst_cpurst", 64'(cpu_rst),  64'd1);
    check("midrst_ready",  64'(rx_ready), 64'd1);
    check("midrst_we",     64'(im_we),    64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_frame(good, 0);
    check_outcome("reload", 1'b1, 1'b0, 2);

    // Maximum legal image: 1024 words, last at address 1023
    do_reset();
    big = '{8'hA5, 8'h04, 8'h00};
    chk = 8'd0;
    for (int i = 0; i < 1024; i++) begin
      w = {8'(i), 8'(i >> 8), ~8'(i), 8'hC3};
      for (int j = 3; j >= 0; j--) begin
        big.push_back(w[j*8 +: 8]);
        chk ^= w[j*8 +: 8];
      end
    end
    big.push_back(chk);
    run_frame(big, 0);
    check_outcome("max", 1'b1, 1'b0, 1024);
    check("max_last_addr", 64'(im_addr), 64'd1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/im_loader.md
Name: im_loader

Overview:
Boot-time program loader that sits directly upstream of the instruction memory (im_4k) and the pc register.
- Receives a framed byte stream and assembles big-endian 32-bit instruction words.
- Writes each word into im_4k through that memory's write port.
- Holds the CPU in reset until the image is fully written and its checksum has been verified.
- On success it releases the CPU, which then fetches from word address 0.

Parameters:
ADDR_W, 10, instruction-memory word-address width (matches im_4k, 1024 words)
MAX_WORDS, 1024, largest accepted image length in words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_valid  in  1  byte available on rx_data
rx_data  in  8  incoming byte
rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a rising edge
im_we  out  1  instruction-memory write strobe, one-cycle pulse per word
im_addr  out  ADDR_W  word address of the write
im_wdata  out  32  instruction word to write
cpu_rst  out  1  active-high hold driven to the pc's rst; 1 = CPU held
done  out  1  image loaded and verified (sticky)
error  out  1  frame rejected (sticky)
word_cnt  out  ADDR_W+1  words written so far

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cpu_rst=1, im_we=0, im_addr=0, im_wdata=0, done=0, error=0, word_cnt=0.
  - Internal byte counter, length register and XOR accumulator are cleared.
- rx_ready is decoded from state: 1 in IDLE, LEN_HI, LEN_LO, DATA and CHK; 0 in RUN and ERR. It is 1 in the first cycle after reset release.
- States and transitions (each transition occurs on an accepted byte only):
  - IDLE: a byte equal to SYNC_BYTE moves to LEN_HI; any other byte is discarded.
  - LEN_HI: byte becomes len[15:8]; go to LEN_LO.
  - LEN_LO: byte becomes len[7:0]. Then:
    - if len > MAX_WORDS, go to ERR;
    - else if len == 0, go to CHK;
    - else go to DATA.
  - DATA: bytes are packed big-endian (first byte -> [31:24], fourth byte -> [7:0]), and each byte is XORed into the accumulator.
    - On the edge accepting the 4th byte: next cycle im_we=1, im_addr=word_cnt[ADDR_W-1:0] (pre-increment value), im_wdata=assembled word; word_cnt increments on that same edge.
    - Write latency is exactly 1 cycle after the accepting edge.
    - After the word with index len-1, go to CHK.
  - CHK: if byte == accumulator, go to RUN; otherwise go to ERR.
  - RUN: cpu_rst=0, done=1. Sticky until rst.
  - ERR: cpu_rst=1, error=1. Sticky until rst.
- im_we is never asserted outside a DATA word completion. im_addr and im_wdata hold their last value when im_we=0.
- Gaps (rx_valid=0 for any number of cycles) between bytes have no effect. No timeout.
- Checksum covers data bytes only; sync and length bytes are excluded.
- Exactly MAX_WORDS words is legal. The final word then uses im_addr=1023 and word_cnt ends at 1024.
- Reset mid-load aborts immediately:
  - already-written im_4k words remain, and cpu_rst stays 1;
  - the next frame must start again with SYNC_BYTE.
- done and error are never both 1.

Decomposition:
- Shared package (loader_pkg):
  - state encoding enum (IDLE, LEN_HI, LEN_LO, DATA, CHK, RUN, ERR);
  - SYNC_BYTE and MAX_WORDS constants.
- One sub-module, word_assembler: 2-bit byte counter, 32-bit shift register and XOR accumulator. It emits word_valid and word_data. The top FSM owns length, word_cnt and the output registers.

Test Plan:
1. Reset behaviour: hold rst=0, then release -> cpu_rst=1, im_we=0, done=0, error=0, word_cnt=0, rx_ready=1.
2. Valid image:
   - Stimulus: 00,A5,00,02,20,08,00,05,00,00,00,08,25.
   - Required: im_we pulses twice: addr0=0x20080005, then addr1=0x00000008, each 1 cycle after its 4th byte.
   - Then done=1, cpu_rst=0, word_cnt=2, rx_ready=0.
3. Bad checksum: same frame but final byte 26 -> both writes occur, then error=1, cpu_rst=1, done=0, rx_ready=0.
4. Oversize: A5,04,01 -> error=1 after the 3rd byte, no im_we pulse, cpu_rst=1.
5. Empty image and gaps:
   - A5,00,00,00 -> done=1, cpu_rst=0, no im_we.
   - Repeat test 2 with 3 idle rx_valid=0 cycles between every byte -> identical writes and outcome.
6. Reset mid-load:
   - Pulse rst low after 6 data bytes of test 2 -> state IDLE, word_cnt=0, cpu_rst=1.
   - Then send the full test-2 frame -> done=1 with the same two writes.
